// File: rtl/multdiv_sequencer_if.sv
// Handshake bundle between the main control unit and the mult/div sequencer.
// The master drives the launch request and the slave returns status and strobes.
interface multdiv_sequencer_if;
    logic [1:0]  CONTROL_MULTDIV;
    logic        START;
    logic [31:0] DIVISOR;
    logic        MULT_CONTROL;
    logic        DIV_CONTROL;
    logic        BUSY;
    logic        DONE;
    logic        HILO_WRITE;
    logic        HILO_SRC;
    logic        DIV_ZERO;

    modport master (
        output CONTROL_MULTDIV, START, DIVISOR,
        input  MULT_CONTROL, DIV_CONTROL, BUSY, DONE, HILO_WRITE, HILO_SRC, DIV_ZERO
    );

    modport slave (
        input  CONTROL_MULTDIV, START, DIVISOR,
        output MULT_CONTROL, DIV_CONTROL, BUSY, DONE, HILO_WRITE, HILO_SRC, DIV_ZERO
    );
endinterface

// File: rtl/multdiv_sequencer.sv
// Sequencer for the shared multiplier/divider: holds the unit enable for a fixed
// cycle count, stalls the main control via BUSY, then strobes the HI/LO write.
module multdiv_sequencer #(
    parameter int MULT_CYCLES = 32,
    parameter int DIV_CYCLES  = 32,
    parameter int CNT_W       = 6
) (
    input  logic               clock,
    input  logic               reset,
    multdiv_sequencer_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        MULT_RUN = 2'd1,
        DIV_RUN  = 2'd2,
        WB       = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES - 1);
    localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             hilo_src_q, hilo_src_d;
    logic             div_zero_q, div_zero_d;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            hilo_src_q <= 1'b0;
            div_zero_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            hilo_src_q <= hilo_src_d;
            div_zero_q <= div_zero_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        hilo_src_d = hilo_src_q;
        div_zero_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.START) begin
                    case (bus.CONTROL_MULTDIV)
                        2'b01: begin
                            state_d    = MULT_RUN;
                            cnt_d      = MULT_LOAD;
                            hilo_src_d = 1'b0;
                        end
                        2'b10: begin
                            // A zero divisor never starts the divider; it only raises the exception.
                            if (bus.DIVISOR == 32'd0) begin
                                div_zero_d = 1'b1;
                            end else begin
                                state_d    = DIV_RUN;
                                cnt_d      = DIV_LOAD;
                                hilo_src_d = 1'b1;
                            end
                        end
                        default: ;
                    endcase
                end
            end
            MULT_RUN, DIV_RUN: begin
                if (cnt_q == '0) begin
                    state_d = WB;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            WB: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Every output is a decode of registered state, so nothing reaches an output combinationally.
    assign bus.MULT_CONTROL = (state_q == MULT_RUN);
    assign bus.DIV_CONTROL  = (state_q == DIV_RUN);
    assign bus.BUSY         = (state_q == MULT_RUN) || (state_q == DIV_RUN);
    assign bus.DONE         = (state_q == WB);
    assign bus.HILO_WRITE   = (state_q == WB);
    assign bus.HILO_SRC     = hilo_src_q;
    assign bus.DIV_ZERO     = div_zero_q;
endmodule

// File: tb/tb_multdiv_sequencer.sv
// Randomized scoreboard bench for multdiv_sequencer: the driver predicts each
// run or exception window, the monitor compares every cycle's outputs against it.
module tb_multdiv_sequencer;
    localparam int MC = 32;
    localparam int DC = 32;

    logic clock = 1'b0;
    logic reset = 1'b0;

    multdiv_sequencer_if bus();

    multdiv_sequencer #(
        .MULT_CYCLES(MC),
        .DIV_CYCLES (DC),
        .CNT_W      (6)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    // One expected event: a run observed in cycles [start, fin) with DONE at fin,
    // or a divide-by-zero pulse at start == fin.
    typedef struct {
        int start;
        int fin;
        bit is_div;
        bit is_dz;
    } exp_t;

    exp_t sb_q[$];
    int   next_accept = 0;
    bit   exp_src     = 1'b0;
    int   n_checks    = 0;
    int   n_pass      = 0;

    logic [6:0] mon_exp;
    exp_t       mon_f;

    // Output vector order: MULT_CONTROL DIV_CONTROL BUSY DONE HILO_WRITE HILO_SRC DIV_ZERO
    function automatic logic [6:0] outs();
        return {bus.MULT_CONTROL, bus.DIV_CONTROL, bus.BUSY, bus.DONE,
                bus.HILO_WRITE, bus.HILO_SRC, bus.DIV_ZERO};
    endfunction

    task automatic check_vec(input string name, input logic [6:0] got, input logic [6:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s cyc=%0d got=%b exp=%b (MULT DIV BUSY DONE HW SRC DZ)",
                      name, cyc, got, exp);
    endtask

    // Monitor: builds the expected output vector from the scoreboard head each cycle.
    always @(negedge clock) begin
        if (reset) begin
            mon_exp = '0;
            while (sb_q.size() > 0 && sb_q[0].fin < cyc) void'(sb_q.pop_front());
            if (sb_q.size() > 0) begin
                mon_f = sb_q[0];
                if (mon_f.is_dz) begin
                    if (cyc == mon_f.fin) mon_exp[0] = 1'b1;
                end else begin
                    if (cyc >= mon_f.start) exp_src = mon_f.is_div;
                    if (cyc >= mon_f.start && cyc < mon_f.fin) begin
                        mon_exp[6] = !mon_f.is_div;
                        mon_exp[5] = mon_f.is_div;
                        mon_exp[4] = 1'b1;
                    end else if (cyc == mon_f.fin) begin
                        mon_exp[3] = 1'b1;
                        mon_exp[2] = 1'b1;
                    end
                end
                if (cyc == mon_f.fin) void'(sb_q.pop_front());
            end
            mon_exp[1] = exp_src;
            check_vec("cycle_outputs", outs(), mon_exp);
        end
    end

    task automatic rand_side();
        bus.START           = 1'b0;
        bus.CONTROL_MULTDIV = 2'($urandom_range(0, 3));
        bus.DIVISOR         = $urandom;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clock);
            rand_side();
        end
    endtask

    // Drive one request for a single cycle; the model decides whether it launches.
    task automatic issue(input logic [1:0] op, input logic st, input logic [31:0] dv);
        int e;
        bus.START           = st;
        bus.CONTROL_MULTDIV = op;
        bus.DIVISOR         = dv;
        e = cyc + 1;
        if (st && e >= next_accept) begin
            if (op == 2'b01) begin
                sb_q.push_back('{e, e + MC, 1'b0, 1'b0});
                next_accept = e + MC + 2;
            end else if (op == 2'b10 && dv != 32'd0) begin
                sb_q.push_back('{e, e + DC, 1'b1, 1'b0});
                next_accept = e + DC + 2;
            end else if (op == 2'b10) begin
                sb_q.push_back('{e, e, 1'b0, 1'b1});
                next_accept = e + 1;
            end
        end
        @(negedge clock);
        rand_side();
    endtask

    // Assert reset between clock edges and confirm the outputs clear before any edge.
    task automatic do_reset(input int hold);
        #2;
        reset = 1'b0;
        sb_q.delete();
        exp_src = 1'b0;
        #1;
        check_vec("reset_async", outs(), 7'b0);
        @(negedge clock);
        repeat (hold) @(negedge clock);
        reset = 1'b1;
        next_accept = cyc + 1;
    endtask

    initial begin
        bus.START           = 1'b0;
        bus.CONTROL_MULTDIV = 2'b00;
        bus.DIVISOR         = 32'd0;
        repeat (3) @(negedge clock);
        check_vec("reset_hold", outs(), 7'b0);
        reset = 1'b1;
        next_accept = cyc + 1;
        idle(5);

        issue(2'b01, 1'b1, 32'd0);
        idle(MC + 3);

        issue(2'b10, 1'b1, 32'd7);
        idle(DC + 12);

        issue(2'b10, 1'b1, 32'd0);
        issue(2'b01, 1'b1, 32'd5);
        idle(MC + 3);

        issue(2'b11, 1'b1, 32'd9);
        idle(2);
        issue(2'b00, 1'b1, 32'd9);
        idle(2);
        issue(2'b01, 1'b1, 32'd1);
        idle(3);
        issue(2'b10, 1'b1, 32'd4);
        idle(MC + 4);

        issue(2'b01, 1'b1, 32'd1);
        idle(8);
        do_reset(1);
        idle(40);
        issue(2'b10, 1'b1, 32'd3);
        idle(DC + 3);

        for (int it = 0; it < 250; it++) begin
            logic [1:0]  op;
            logic        st;
            logic [31:0] dv;
            op = 2'($urandom_range(0, 3));
            st = ($urandom_range(0, 7) != 0);
            dv = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
            issue(op, st, dv);
            idle($urandom_range(0, 3));
            if ($urandom_range(0, 9) == 0) idle(MC);
            if (it == 120) do_reset(2);
        end

        for (int w = 0; w < 200 && sb_q.size() > 0; w++) idle(1);
        n_checks++;
        if (sb_q.size() == 0) n_pass++;
        else $display("FAIL drain pending=%0d required=0", sb_q.size());
        idle(2);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/multdiv_sequencer.md
Name: multdiv_sequencer

Overview:
- Multi-cycle sequencer for the shared multiplier/divider unit.
- Accepts a one-cycle launch request from the main control unit and drives the mult/div enables for a fixed number of cycles.
- Signals BUSY so the main control stalls, then issues a single HI/LO write strobe with the correct source select.
- Detects divide-by-zero at launch and raises an exception pulse instead of running the divider.

Parameters:
MULT_CYCLES, 32, number of cycles MULT_CONTROL is held high per multiply (legal: >=1)
DIV_CYCLES, 32, number of cycles DIV_CONTROL is held high per divide (legal: >=1)
CNT_W, 6, cycle counter width; must satisfy 2^CNT_W > max(MULT_CYCLES, DIV_CYCLES)

Ports:
clock  in  1  system clock; all state changes on the rising edge
reset  in  1  asynchronous, active-low reset
CONTROL_MULTDIV  in  2  operation select: 00 none, 01 mult, 10 div, 11 reserved
START  in  1  launch strobe from the main control; sampled only in IDLE
DIVISOR  in  32  divider operand B; sampled only at a div launch, for the zero check
MULT_CONTROL  out  1  multiplier enable, high for the whole multiply run
DIV_CONTROL  out  1  divider enable, high for the whole divide run
BUSY  out  1  high while a run is in progress; main control stalls on it
DONE  out  1  one-cycle completion pulse
HILO_WRITE  out  1  one-cycle HI/LO register write strobe, coincident with DONE
HILO_SRC  out  1  HI/LO source select: 0 multiplier, 1 divider; held until the next launch
DIV_ZERO  out  1  one-cycle divide-by-zero exception pulse

Behaviour:
- Clock/reset: one clock domain (clock). reset is asynchronous and active-low.
- Reset values: state IDLE, counter 0, and every output 0 (MULT_CONTROL, DIV_CONTROL, BUSY, DONE, HILO_WRITE, HILO_SRC, DIV_ZERO).
- Outputs: all are registered or decoded from registered state; no combinational path from any input to any output.
- States: IDLE, MULT_RUN, DIV_RUN, WB.
- IDLE, START=1, CONTROL_MULTDIV=01: next state MULT_RUN; counter <= MULT_CYCLES-1; HILO_SRC <= 0.
- IDLE, START=1, CONTROL_MULTDIV=10, DIVISOR!=0: next state DIV_RUN; counter <= DIV_CYCLES-1; HILO_SRC <= 1.
- IDLE, START=1, CONTROL_MULTDIV=10, DIVISOR==0:
  - Stay in IDLE; DIV_ZERO=1 for exactly the next cycle.
  - HILO_SRC unchanged; BUSY, DIV_CONTROL and HILO_WRITE stay 0.
- IDLE, START=1, CONTROL_MULTDIV=00 or 11: ignored; no output changes.
- MULT_RUN / DIV_RUN:
  - The matching enable (MULT_CONTROL or DIV_CONTROL) =1 and BUSY=1; the other enable =0.
  - Counter decrements each cycle. When counter==0, next state is WB.
  - The run therefore lasts exactly MULT_CYCLES or DIV_CYCLES cycles.
- WB: DONE=1, HILO_WRITE=1, BUSY=0, both enables =0; next state IDLE unconditionally.
- Latency: START accepted at edge k -> enable and BUSY high during cycles k+1 .. k+N -> DONE and HILO_WRITE high in cycle k+N+1 -> IDLE at k+N+2. N is MULT_CYCLES or DIV_CYCLES.
- No queueing: START in MULT_RUN, DIV_RUN or WB is ignored. The next launch is accepted in IDLE, at the earliest the cycle after WB.
- Sampling window: CONTROL_MULTDIV and DIVISOR matter only on the launch edge; changes during a run have no effect.
- MULT_CONTROL and DIV_CONTROL are never high simultaneously. DONE, HILO_WRITE and DIV_ZERO are never high in the same cycle as BUSY.
- Reset mid-run: all outputs drop to 0 immediately (asynchronously). The interrupted operation produces no DONE or HILO_WRITE after reset is released. HILO_SRC returns to 0.
- Counter width: CNT_W bits, unsigned; it never wraps because it is reloaded on every launch and leaves the run at 0.

Test Plan:
1. Reset: hold reset=0 for 3 cycles -> all outputs 0; release, idle 5 cycles with START=0 -> all outputs remain 0.
2. Multiply: START=1, CONTROL_MULTDIV=01 for one cycle -> MULT_CONTROL=1 and BUSY=1 for exactly 32 cycles; then DONE=1, HILO_WRITE=1, HILO_SRC=0 for 1 cycle; DIV_CONTROL=0 throughout.
3. Divide: START=1, CONTROL_MULTDIV=10, DIVISOR=7 -> DIV_CONTROL=1 for 32 cycles; then DONE=1 and HILO_WRITE=1 for 1 cycle; HILO_SRC=1 and still 1 ten cycles later.
4. Divide-by-zero: START=1, CONTROL_MULTDIV=10, DIVISOR=0 -> DIV_ZERO=1 for 1 cycle; BUSY, DIV_CONTROL, DONE and HILO_WRITE stay 0; a multiply launched the next cycle runs normally.
5. Ignored requests: START with CONTROL_MULTDIV=11, then with 00 -> no output change. START with op 10 at run cycle 5 of a multiply -> run completes in 32 cycles with HILO_SRC=0 and no divide follows.
6. Reset mid-run: launch a multiply, assert reset=0 at run cycle 10 -> outputs 0 without waiting for a clock edge; after release, no DONE within 40 cycles; a fresh divide (DIVISOR=3) then completes normally.
